frame_stream_feeder: RTL and testbench

Upstream-side driver for the stereo frame buffer. It accepts a raster pixel stream through a valid/ready handshake and drives the buffer's shift-enable, pixel data and synchronous clear. It tracks raster and window position, and reports in every cycle whether the two windows currently held in the buffer (older frame and newer frame, same position) are complete and lie inside the frame.

---
 rtl/frame_stream_feeder_pkg.sv | 46 ++++
 rtl/frame_stream_feeder_raster_counter.sv | 51 +++++
 rtl/frame_stream_feeder.sv | 170 +++++++++++++++++
 tb/tb_frame_stream_feeder.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_stream_feeder_pkg.sv
// Shared definitions for the stereo frame buffer feeder and the buffer itself:
// buffer depth formula, width helper and raster stepping.
package frame_stream_feeder_pkg;

  typedef enum logic [1:0] {
    ST_CLR    = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESYNC = 2'd2
  } feeder_state_t;

  // One raster step: next position plus the wrap flags that produced it.
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic        x_wrap;
    logic        y_wrap;
  } raster_step_t;

  // Bits needed to hold values 0..value-1 (never less than 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Buffer depth: enough pixels to hold a full frame plus one window of the
  // next frame at the same position.
  function automatic int fill_n(input int fw, input int fh, input int ww, input int wh);
    return fw * (fh + wh - 1) + ww;
  endfunction

  // Advance (x, y) by one pixel in raster order over a w x h frame.
  function automatic raster_step_t raster_next(input logic [31:0] x, input logic [31:0] y,
                                               input int w, input int h);
    raster_step_t s;
    s.x_wrap = (x == 32'(w - 1));
    s.y_wrap = s.x_wrap && (y == 32'(h - 1));
    s.x      = s.x_wrap ? 32'd0 : x + 32'd1;
    s.y      = s.x_wrap ? (s.y_wrap ? 32'd0 : y + 32'd1) : y;
    return s;
  endfunction

endpackage

// File: rtl/frame_stream_feeder_raster_counter.sv
// Raster x/y counter with enable, synchronous clear and an end-of-frame pulse.
// Also exposes its next value so callers can register status alongside it.
module frame_stream_feeder_raster_counter
  import frame_stream_feeder_pkg::*;
#(
  parameter int frame_w = 100,
  parameter int frame_h = 100,
  parameter int x_bits  = 7,
  parameter int y_bits  = 7
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  output logic [x_bits-1:0] x,
  output logic [y_bits-1:0] y,
  output logic [x_bits-1:0] x_nxt,
  output logic [y_bits-1:0] y_nxt,
  output logic              eof
);

  raster_step_t step;

  // Next position: clear wins over enable; eof pulses on the wrapping step.
  always_comb begin
    step  = raster_next(32'(x), 32'(y), frame_w, frame_h);
    x_nxt = x;
    y_nxt = y;
    eof   = 1'b0;
    if (clr) begin
      x_nxt = '0;
      y_nxt = '0;
    end else if (en) begin
      x_nxt = x_bits'(step.x);
      y_nxt = y_bits'(step.y);
      eof   = step.y_wrap;
    end
  end

  // Position register.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_nxt;
      y <= y_nxt;
    end
  end

endmodule

// File: rtl/frame_stream_feeder.sv
// Upstream driver for the stereo frame buffer: takes a raster pixel stream,
// shifts it into the buffer, and reports whether the buffered window pair is
// complete and inside the frame.
module frame_stream_feeder
  import frame_stream_feeder_pkg::*;
#(
  parameter int pixel_dept = 5,
  parameter int frame_w    = 100,
  parameter int frame_h    = 100,
  parameter int window_w   = 10,
  parameter int window_h   = 10
) (
  input  logic                      pclk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [pixel_dept-1:0]     s_data,
  input  logic                      s_sof,
  input  logic                      hold,
  output logic                      en_out,
  output logic [pixel_dept-1:0]     data_out,
  output logic                      fb_clr,
  output logic                      win_valid,
  output logic [clog2(frame_w)-1:0] win_x,
  output logic [clog2(frame_h)-1:0] win_y,
  output logic [15:0]               frame_cnt,
  output logic                      sync_err,
  output logic [1:0]                dbg_state
);

  localparam int X_BITS    = clog2(frame_w);
  localparam int Y_BITS    = clog2(frame_h);
  localparam int FILL_N    = fill_n(frame_w, frame_h, window_w, window_h);
  localparam int FILL_BITS = clog2(FILL_N + 1);
  localparam logic [FILL_BITS-1:0] FILL_FULL = FILL_BITS'(FILL_N);
  localparam logic [X_BITS-1:0]    WIN_X_MAX = X_BITS'(frame_w - window_w);
  localparam logic [Y_BITS-1:0]    WIN_Y_MAX = Y_BITS'(frame_h - window_h);

  // Handshake: a beat happens in any cycle where s_valid and s_ready are both
  // high. s_ready may depend on s_valid/s_sof (a misplaced SOF is refused), so
  // upstream must keep s_data/s_sof stable while s_valid=1 and s_ready=0.

  feeder_state_t state, state_nxt;

  logic                 beat;
  logic                 at_origin;
  logic                 sof_misplaced;
  logic                 set_err;
  logic                 clr_pos;
  logic                 fill_full;
  logic [FILL_BITS-1:0] fill, fill_nxt;
  logic [X_BITS-1:0]    in_x, in_x_nxt, win_x_nxt;
  logic [Y_BITS-1:0]    in_y, in_y_nxt, win_y_nxt;
  logic                 in_eof;
  logic                 win_eof;
  logic                 win_valid_nxt;
  logic                 unused_nxt;

  assign at_origin     = (in_x == '0) && (in_y == '0);
  assign sof_misplaced = s_valid & s_sof & ~at_origin;
  assign beat          = s_valid & s_ready;
  assign clr_pos       = (state == ST_RESYNC);
  assign fill_full     = (fill == FILL_FULL);
  assign en_out        = beat;
  assign data_out      = s_data;
  assign dbg_state     = state;
  assign unused_nxt    = ^{in_x_nxt, in_y_nxt, win_eof};

  // State register.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) state <= ST_CLR;
    else      state <= state_nxt;
  end

  // Next state, handshake and buffer clear; RUN stalls on hold, the clear
  // states always move on.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    fb_clr    = 1'b0;
    set_err   = 1'b0;
    case (state)
      ST_CLR: begin
        fb_clr    = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        s_ready = ~hold & ~sof_misplaced;
        if (~hold & sof_misplaced) begin
          state_nxt = ST_RESYNC;
          set_err   = 1'b1;
        end else if (~hold & s_valid & at_origin & ~s_sof) begin
          set_err = 1'b1;
        end
      end
      ST_RESYNC: begin
        fb_clr    = 1'b1;
        state_nxt = ST_RUN;
      end
      default: begin
        fb_clr    = 1'b1;
        state_nxt = ST_CLR;
      end
    endcase
  end

  // Input raster position.
  frame_stream_feeder_raster_counter #(
    .frame_w (frame_w),
    .frame_h (frame_h),
    .x_bits  (X_BITS),
    .y_bits  (Y_BITS)
  ) u_in_pos (
    .pclk  (pclk),
    .rst   (rst),
    .en    (beat),
    .clr   (clr_pos),
    .x     (in_x),
    .y     (in_y),
    .x_nxt (in_x_nxt),
    .y_nxt (in_y_nxt),
    .eof   (in_eof)
  );

  // Window position: only moves once the buffer is full.
  frame_stream_feeder_raster_counter #(
    .frame_w (frame_w),
    .frame_h (frame_h),
    .x_bits  (X_BITS),
    .y_bits  (Y_BITS)
  ) u_win_pos (
    .pclk  (pclk),
    .rst   (rst),
    .en    (beat & fill_full),
    .clr   (clr_pos),
    .x     (win_x),
    .y     (win_y),
    .x_nxt (win_x_nxt),
    .y_nxt (win_y_nxt),
    .eof   (win_eof)
  );

  // Fill level, saturating at the buffer depth.
  always_comb begin
    fill_nxt = fill;
    if (clr_pos)                fill_nxt = '0;
    else if (beat & ~fill_full) fill_nxt = fill + 1'b1;
  end

  // Window status computed from next-cycle contents so it lands with the shift.
  assign win_valid_nxt = (fill_nxt == FILL_FULL) &&
                         (win_x_nxt <= WIN_X_MAX) &&
                         (win_y_nxt <= WIN_Y_MAX);

  // Fill, window status, frame count and sticky sync error registers.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      fill      <= '0;
      win_valid <= 1'b0;
      frame_cnt <= '0;
      sync_err  <= 1'b0;
    end else begin
      fill      <= fill_nxt;
      win_valid <= win_valid_nxt;
      if (in_eof) frame_cnt <= frame_cnt + 16'd1;
      if (set_err) sync_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_stream_feeder.sv
// Bench for frame_stream_feeder with an 8x4 frame and 3x2 window (buffer 43).
module tb_frame_stream_feeder;

  localparam int PD = 5;
  localparam int FW = 8;
  localparam int FH = 4;
  localparam int WW = 3;
  localparam int WH = 2;
  localparam int FILL = 43;
  localparam int S_CLR = 0;
  localparam int S_RUN = 1;
  localparam int S_RESYNC = 2;
  localparam int MAX_WAIT = 50;
  localparam int NV = 12;

  logic          pclk;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [PD-1:0] s_data;
  logic          s_sof;
  logic          hold;
  logic          en_out;
  logic [PD-1:0] data_out;
  logic          fb_clr;
  logic          win_valid;
  logic [2:0]    win_x;
  logic [1:0]    win_y;
  logic [15:0]   frame_cnt;
  logic          sync_err;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [PD-1:0] exp_q[$];

  typedef struct {
    int   k;
    logic v;
    int   x;
    int   y;
    int   fc;
  } vec_t;
  vec_t vecs[NV];

  frame_stream_feeder #(
    .pixel_dept (PD),
    .frame_w    (FW),
    .frame_h    (FH),
    .window_w   (WW),
    .window_h   (WH)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_sof     (s_sof),
    .hold      (hold),
    .en_out    (en_out),
    .data_out  (data_out),
    .fb_clr    (fb_clr),
    .win_valid (win_valid),
    .win_x     (win_x),
    .win_y     (win_y),
    .frame_cnt (frame_cnt),
    .sync_err  (sync_err),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #100000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: window state after k beats since the last sync point.
  function automatic void model(input int k, output logic v, output int x,
                                output int y, output int fc);
    int adv;
    adv = (k > FILL) ? k - FILL : 0;
    x   = adv % FW;
    y   = (adv / FW) % FH;
    fc  = (k / (FW * FH)) % 65536;
    v   = (k >= FILL) && (x <= FW - WW) && (y <= FH - WH);
  endfunction

  // Driver tasks; they start and end 1 time unit after a falling edge.
  task automatic idle(input int n);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    repeat (n) #10;
  endtask

  task automatic send_beat(input logic [PD-1:0] d, input logic sof);
    bit taken;
    int guard;
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    exp_q.push_back(d);
    taken = 1'b0;
    guard = 0;
    while (!taken && guard < MAX_WAIT) begin
      #2;
      taken = s_ready;
      #8;
      guard++;
    end
    if (!taken) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout s_ready=0 for %0d cycles required=1", MAX_WAIT);
    end
  endtask

  // Scoreboard: each shift into the buffer must carry the next expected pixel.
  always @(negedge pclk) begin
    #3;
    if (en_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat data_out=%0d required=no beat", data_out);
      end else begin
        check("beat_data", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [PD-1:0] d;
    logic mv;
    int mx, my, mfc;
    int k;

    vecs[0]  = '{k: 1,  v: 1'b0, x: 0, y: 0, fc: 0};
    vecs[1]  = '{k: 32, v: 1'b0, x: 0, y: 0, fc: 1};
    vecs[2]  = '{k: 42, v: 1'b0, x: 0, y: 0, fc: 1};
    vecs[3]  = '{k: 43, v: 1'b1, x: 0, y: 0, fc: 1};
    vecs[4]  = '{k: 48, v: 1'b1, x: 5, y: 0, fc: 1};
    vecs[5]  = '{k: 49, v: 1'b0, x: 6, y: 0, fc: 1};
    vecs[6]  = '{k: 50, v: 1'b0, x: 7, y: 0, fc: 1};
    vecs[7]  = '{k: 51, v: 1'b1, x: 0, y: 1, fc: 1};
    vecs[8]  = '{k: 67, v: 1'b0, x: 0, y: 3, fc: 2};
    vecs[9]  = '{k: 72, v: 1'b0, x: 5, y: 3, fc: 2};
    vecs[10] = '{k: 75, v: 1'b1, x: 0, y: 0, fc: 2};
    vecs[11] = '{k: 96, v: 1'b1, x: 5, y: 2, fc: 3};

    rst = 1'b0; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; hold = 1'b0;
    @(negedge pclk); #1;

    // Reset values while held in reset
    #2;
    check("rst_fb_clr", 32'(fb_clr), 1);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_en_out", 32'(en_out), 0);
    check("rst_win_valid", 32'(win_valid), 0);
    check("rst_win_x", 32'(win_x), 0);
    check("rst_win_y", 32'(win_y), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_sync_err", 32'(sync_err), 0);
    check("rst_state", 32'(dbg_state), S_CLR);
    #8;

    // Release: one CLR cycle, then RUN
    rst = 1'b1;
    #2;
    check("clr_fb_clr", 32'(fb_clr), 1);
    check("clr_s_ready", 32'(s_ready), 0);
    check("clr_state", 32'(dbg_state), S_CLR);
    #8;
    #2;
    check("run_fb_clr", 32'(fb_clr), 0);
    check("run_s_ready", 32'(s_ready), 1);
    check("run_state", 32'(dbg_state), S_RUN);
    check("run_win_valid", 32'(win_valid), 0);
    #8;

    // Table-driven streaming: continuous until the buffer fills, gaps after
    k = 0;
    for (int r = 0; r < NV; r++) begin
      while (k < vecs[r].k) begin
        if (k >= FILL && $urandom_range(0, 3) == 0) idle(1);
        send_beat(PD'($urandom_range(0, 31)), (k % 32) == 0);
        k++;
      end
      s_valid = 1'b0;
      s_sof   = 1'b0;
      #2;
      check($sformatf("row%0d_win_valid", r), 32'(win_valid), 32'(vecs[r].v));
      check($sformatf("row%0d_win_x", r), 32'(win_x), 32'(vecs[r].x));
      check($sformatf("row%0d_win_y", r), 32'(win_y), 32'(vecs[r].y));
      check($sformatf("row%0d_frame_cnt", r), 32'(frame_cnt), 32'(vecs[r].fc));
      check($sformatf("row%0d_queue", r), 32'(exp_q.size()), 0);
      #8;
    end

    // Hold for 5 cycles with a pending beat
    d = PD'($urandom_range(0, 31));
    s_valid = 1'b1; s_data = d; s_sof = 1'b1; hold = 1'b1;
    model(k, mv, mx, my, mfc);
    for (int c = 0; c < 5; c++) begin
      #2;
      check("hold_s_ready", 32'(s_ready), 0);
      check("hold_en_out", 32'(en_out), 0);
      check("hold_win_valid", 32'(win_valid), 32'(mv));
      check("hold_win_x", 32'(win_x), 32'(mx));
      check("hold_win_y", 32'(win_y), 32'(my));
      check("hold_frame_cnt", 32'(frame_cnt), 32'(mfc));
      #8;
    end
    hold = 1'b0;
    send_beat(d, 1'b1);
    k++;
    s_valid = 1'b0; s_sof = 1'b0;
    model(k, mv, mx, my, mfc);
    #2;
    check("resume_win_valid", 32'(win_valid), 32'(mv));
    check("resume_win_x", 32'(win_x), 32'(mx));
    check("resume_win_y", 32'(win_y), 32'(my));
    #8;

    // Move input position to (5,1), then present a misplaced SOF
    while (k < 109) begin
      send_beat(PD'($urandom_range(0, 31)), (k % 32) == 0);
      k++;
    end
    d = PD'($urandom_range(0, 31));
    s_valid = 1'b1; s_data = d; s_sof = 1'b1;
    exp_q.push_back(d);
    #2;
    check("sof_stall_ready", 32'(s_ready), 0);
    check("sof_stall_en", 32'(en_out), 0);
    check("sof_stall_fb_clr", 32'(fb_clr), 0);
    check("sof_stall_err", 32'(sync_err), 0);
    #8;
    #2;
    check("resync_state", 32'(dbg_state), S_RESYNC);
    check("resync_fb_clr", 32'(fb_clr), 1);
    check("resync_ready", 32'(s_ready), 0);
    check("resync_err", 32'(sync_err), 1);
    check("resync_frame_cnt", 32'(frame_cnt), 3);
    #8;
    #2;
    check("resync_accept_state", 32'(dbg_state), S_RUN);
    check("resync_accept_ready", 32'(s_ready), 1);
    check("resync_accept_en", 32'(en_out), 1);
    #8;
    s_valid = 1'b0; s_sof = 1'b0;
    #2;
    check("after_resync_win_valid", 32'(win_valid), 0);
    check("after_resync_win_x", 32'(win_x), 0);
    check("after_resync_win_y", 32'(win_y), 0);
    check("after_resync_frame_cnt", 32'(frame_cnt), 3);
    #8;

    // Refill from the resync point: fill started at 1
    k = 1;
    while (k < 42) begin
      send_beat(PD'($urandom_range(0, 31)), (k % 32) == 0);
      k++;
    end
    s_valid = 1'b0;
    #2;
    check("refill42_win_valid", 32'(win_valid), 0);
    #8;
    send_beat(PD'($urandom_range(0, 31)), 1'b0);
    k++;
    s_valid = 1'b0;
    #2;
    check("refill43_win_valid", 32'(win_valid), 1);
    check("refill43_win_x", 32'(win_x), 0);
    check("refill43_win_y", 32'(win_y), 0);
    check("refill43_frame_cnt", 32'(frame_cnt), 4);
    check("refill43_sync_err", 32'(sync_err), 1);
    #8;

    // Asynchronous reset mid-frame, between clock edges
    rst = 1'b0;
    #1;
    check("arst_fb_clr", 32'(fb_clr), 1);
    check("arst_s_ready", 32'(s_ready), 0);
    check("arst_win_valid", 32'(win_valid), 0);
    check("arst_win_x", 32'(win_x), 0);
    check("arst_win_y", 32'(win_y), 0);
    check("arst_frame_cnt", 32'(frame_cnt), 0);
    check("arst_sync_err", 32'(sync_err), 0);
    check("arst_state", 32'(dbg_state), S_CLR);
    #9;
    rst = 1'b1;
    #2;
    check("arst_clr_fb_clr", 32'(fb_clr), 1);
    check("arst_clr_state", 32'(dbg_state), S_CLR);
    #8;
    #2;
    check("arst_run_ready", 32'(s_ready), 1);
    check("arst_run_fb_clr", 32'(fb_clr), 0);
    #8;

    // First beat at (0,0) without SOF: accepted, flags sync_err
    send_beat(PD'($urandom_range(0, 31)), 1'b0);
    s_valid = 1'b0;
    #2;
    check("nosof_sync_err", 32'(sync_err), 1);
    check("nosof_win_valid", 32'(win_valid), 0);
    check("nosof_frame_cnt", 32'(frame_cnt), 0);
    check("final_queue", 32'(exp_q.size()), 0);
    #8;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
